pipe_stage_chain: RTL and testbench
===================================

Name: pipe_stage_chain

Overview:
- Parametrised chain of DEPTH pipeline stages that carries a WIDTH-bit payload, a valid bit, a destination-register tag and a RegWrite bit from one pipeline boundary to the next.
- Adds what a bare pipeline register does not have: per-stage stall with automatic bubble insertion, per-stage flush (squash), and a two-port forwarding query across all in-flight stages.
- Sits between the decode and writeback sections of the pipelined LEGv8 datapath. It replaces the individually instantiated per-signal pipeline registers.

Parameters:
- WIDTH, 64: payload bits per stage.
- DEPTH, 3: number of stages, minimum 1. Stage 0 is youngest; stage DEPTH-1 is oldest.
- REGW, 5: register-tag width.
- ZERO_REG, 31: register index that never produces a forwarding hit (XZR).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_data  in  WIDTH  payload entering stage 0.
- in_valid  in  1  payload is a real instruction.
- in_rd  in  REGW  destination register tag.
- in_regwrite  in  1  instruction writes in_rd.
- stall_at  in  DEPTH  bit k requests that stage k hold its contents.
- flush  in  DEPTH  bit k squashes stage k.
- out_data  out  WIDTH  stage DEPTH-1 payload.
- out_valid  out  1  stage DEPTH-1 valid.
- out_rd  out  REGW  stage DEPTH-1 tag.
- out_regwrite  out  1  stage DEPTH-1 RegWrite, gated by valid.
- q_rs_a  in  REGW  forwarding query register A.
- q_rs_b  in  REGW  forwarding query register B.
- fwd_hit_a  out  1  query A matched an in-flight stage.
- fwd_hit_b  out  1  query B matched an in-flight stage.
- fwd_data_a  out  WIDTH  payload of the matching stage for A; 0 when no hit.
- fwd_data_b  out  WIDTH  payload of the matching stage for B; 0 when no hit.
- busy  out  1  OR of all stage valid bits.

Behaviour:
- Reset (sync, active-high), on the clk edge where reset=1:
  - every stage valid=0, data=0, rd=0, regwrite=0.
  - all outputs 0 the cycle after.
  - Reset overrides stall_at and flush.
  - Reset asserted mid-stream discards all in-flight contents; nothing drains.
- Effective hold: h[k] = OR(stall_at[j]) for j>=k. A stalled stage freezes all younger stages behind it.
- Per stage k, per edge, in priority order:
  1. flush[k]=1: valid, regwrite cleared; data/rd may keep their old values but are don't-care. Flush beats hold.
  2. h[k]=1: hold all fields.
  3. k=0: load in_* fields.
  4. k>0 and h[k-1]=1: load a bubble (valid=0, regwrite=0).
  5. otherwise: load stage k-1.
- Latency: with no stall, an input sampled at edge t appears on out_* after edge t+DEPTH-1.
  - Stage 0 holds the input after edge t; out_* show stage DEPTH-1.
  - Latency is DEPTH cycles counting the sampling edge.
- When stage 0 is held, in_* is ignored. The upstream producer must also stall; no internal buffering.
- Stored regwrite is in_regwrite AND in_valid.
- out_regwrite = regwrite AND valid of stage DEPTH-1.
- Forwarding (combinational from stage state):
  - Candidate stage k: valid AND regwrite AND rd==query AND rd!=ZERO_REG.
  - If several stages match, the lowest k (youngest) wins.
  - No hit → hit=0, data=0.
- Query ports never observe in_* (no input bypass). Stage contents only.
- DEPTH=1: the hold/bubble rules reduce to hold or load; forwarding scans the single stage.
- Simultaneous flush[k] and stall_at[k]: the stage is squashed, and younger stages still hold.

Optional Feature:
- Macro: PIPE_STAGE_FWD_EN.
- Defined: the forwarding query logic is built as described above.
- Undefined:
  - fwd_hit_a/b and fwd_data_a/b are tied to 0.
  - q_rs_a/b are unused.
  - No comparator logic is instantiated.
  - All other behaviour is identical.

Test Plan:
- Reset and latency, DEPTH=3: hold reset 2 cycles, then drive in_data=0xA5, valid=1, rd=3 at edge 0 → out_data=0xA5, out_valid=1 after edge 2. All outputs 0 during and right after reset.
- Stall and bubble: stream values 1,2,3,4; assert stall_at=3'b010 for one cycle while value 2 is in stage 1 → value 2 is held one extra cycle, a bubble (out_valid=0) reaches the output once, and the output order is 1,2,3,4 with nothing lost or duplicated.
- Flush priority: stage 1 holds valid value 7, with stall_at[1]=1 and flush[1]=1 on the same edge → stage 1 valid=0 next cycle, stage 0 held, value 7 never reaches out_valid=1.
- Forwarding: stage 0 holds rd=5, data=0x11 and stage 2 holds rd=5, data=0x22, both regwrite=1; set q_rs_a=5 → fwd_hit_a=1, fwd_data_a=0x11. Set q_rs_b=31 with a stage holding rd=31 → fwd_hit_b=0, fwd_data_b=0.
- Invalid/no-write: in_valid=0 with in_regwrite=1 and rd=4; query 4 while it is in flight → fwd_hit=0, out_regwrite=0 at the output.
- Mid-stream reset: three valid entries in flight; assert reset one cycle → busy=0 and out_valid=0 the next cycle. Build without PIPE_STAGE_FWD_EN → fwd_hit_a/b stay 0 for the forwarding scenario.

Source files
------------

// File: rtl/pipe_stage_chain_if.sv
// Bundle of payload, stall/flush controls, forwarding query and status signals
// between the decode/writeback logic and pipe_stage_chain.
interface pipe_stage_chain_if #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 3,
    parameter int REGW  = 5
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic [REGW-1:0]  in_rd;
    logic             in_regwrite;
    logic [DEPTH-1:0] stall_at;
    logic [DEPTH-1:0] flush;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic [REGW-1:0]  out_rd;
    logic             out_regwrite;
    logic [REGW-1:0]  q_rs_a;
    logic [REGW-1:0]  q_rs_b;
    logic             fwd_hit_a;
    logic             fwd_hit_b;
    logic [WIDTH-1:0] fwd_data_a;
    logic [WIDTH-1:0] fwd_data_b;
    logic             busy;

    modport master (
        output in_data, in_valid, in_rd, in_regwrite, stall_at, flush, q_rs_a, q_rs_b,
        input  out_data, out_valid, out_rd, out_regwrite,
        input  fwd_hit_a, fwd_hit_b, fwd_data_a, fwd_data_b, busy
    );

    modport slave (
        input  in_data, in_valid, in_rd, in_regwrite, stall_at, flush, q_rs_a, q_rs_b,
        output out_data, out_valid, out_rd, out_regwrite,
        output fwd_hit_a, fwd_hit_b, fwd_data_a, fwd_data_b, busy
    );
endinterface

// File: rtl/pipe_stage_chain.sv
// DEPTH-stage payload/valid/rd/RegWrite pipeline with stall, bubble insertion and flush.
// Define PIPE_STAGE_FWD_EN to build the two-port forwarding query; otherwise fwd_* are 0.
module pipe_stage_chain #(
    parameter int WIDTH    = 64,
    parameter int DEPTH    = 3,
    parameter int REGW     = 5,
    parameter int ZERO_REG = 31
) (
    input  logic              clk,
    input  logic              reset,
    pipe_stage_chain_if.slave bus
);

    typedef struct packed {
        logic             valid;
        logic             regwrite;
        logic [REGW-1:0]  rd;
        logic [WIDTH-1:0] data;
    } stage_t;

    stage_t           stage_q [DEPTH];
    logic [DEPTH-1:0] hold;

    // A stall anywhere downstream freezes every younger stage.
    always_comb begin
        logic acc;
        acc  = 1'b0;
        hold = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            acc     = acc | bus.stall_at[k];
            hold[k] = acc;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            stage_t stage_d;

            if (gi == 0) begin : g_head
                always_comb begin
                    stage_d = stage_q[0];
                    if (bus.flush[0]) begin
                        stage_d.valid    = 1'b0;
                        stage_d.regwrite = 1'b0;
                    end else if (!hold[0]) begin
                        stage_d.valid    = bus.in_valid;
                        stage_d.regwrite = bus.in_regwrite & bus.in_valid;
                        stage_d.rd       = bus.in_rd;
                        stage_d.data     = bus.in_data;
                    end
                end
            end else begin : g_body
                always_comb begin
                    stage_d = stage_q[gi];
                    if (bus.flush[gi]) begin
                        stage_d.valid    = 1'b0;
                        stage_d.regwrite = 1'b0;
                    end else if (!hold[gi]) begin
                        if (hold[gi-1]) begin
                            // Upstream is frozen: pass a bubble instead of duplicating it.
                            stage_d.valid    = 1'b0;
                            stage_d.regwrite = 1'b0;
                        end else begin
                            stage_d = stage_q[gi-1];
                        end
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    stage_q[gi] <= '0;
                end else begin
                    stage_q[gi] <= stage_d;
                end
            end
        end
    endgenerate

    assign bus.out_data     = stage_q[DEPTH-1].data;
    assign bus.out_valid    = stage_q[DEPTH-1].valid;
    assign bus.out_rd       = stage_q[DEPTH-1].rd;
    assign bus.out_regwrite = stage_q[DEPTH-1].regwrite & stage_q[DEPTH-1].valid;

    always_comb begin
        bus.busy = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            bus.busy = bus.busy | stage_q[k].valid;
        end
    end

`ifdef PIPE_STAGE_FWD_EN
    localparam logic [REGW-1:0] ZERO_TAG = REGW'(ZERO_REG);

    // Scan oldest to youngest so the youngest matching stage overwrites older hits.
    always_comb begin
        bus.fwd_hit_a  = 1'b0;
        bus.fwd_data_a = '0;
        bus.fwd_hit_b  = 1'b0;
        bus.fwd_data_b = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (stage_q[k].valid && stage_q[k].regwrite && (stage_q[k].rd != ZERO_TAG)) begin
                if (stage_q[k].rd == bus.q_rs_a) begin
                    bus.fwd_hit_a  = 1'b1;
                    bus.fwd_data_a = stage_q[k].data;
                end
                if (stage_q[k].rd == bus.q_rs_b) begin
                    bus.fwd_hit_b  = 1'b1;
                    bus.fwd_data_b = stage_q[k].data;
                end
            end
        end
    end
`else
    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{bus.q_rs_a, bus.q_rs_b, ZERO_REG[0]};

    assign bus.fwd_hit_a  = 1'b0;
    assign bus.fwd_hit_b  = 1'b0;
    assign bus.fwd_data_a = '0;
    assign bus.fwd_data_b = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed table-driven bench for pipe_stage_chain (DEPTH=3); forwarding
// expectations follow whether PIPE_STAGE_FWD_EN is defined for the build.
module tb_pipe_stage_chain;
    localparam int WIDTH = 64;
    localparam int DEPTH = 3;
    localparam int REGW  = 5;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipe_stage_chain_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .REGW(REGW)) bus ();

    pipe_stage_chain #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .REGW(REGW), .ZERO_REG(31)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic        v;
        logic [63:0] d;
        logic [4:0]  rd;
        logic        rw;
        logic [2:0]  st;
        logic [2:0]  fl;
        logic [4:0]  qa;
        logic [4:0]  qb;
        logic        e_v;
        logic [63:0] e_d;
        logic [4:0]  e_rd;
        logic        e_rw;
        logic        e_busy;
        logic        e_ha;
        logic [63:0] e_da;
        logic        e_hb;
        logic [63:0] e_db;
    } vec_t;

    vec_t tbl[$];
    int   total = 0;
    int   bad   = 0;

    function automatic vec_t mk(
        logic v, logic [63:0] d, logic [4:0] rd, logic rw, logic [2:0] st, logic [2:0] fl,
        logic [4:0] qa, logic [4:0] qb,
        logic ev, logic [63:0] ed, logic [4:0] erd, logic erw, logic eb,
        logic eha, logic [63:0] eda, logic ehb, logic [63:0] edb);
        vec_t r;
        r.v = v; r.d = d; r.rd = rd; r.rw = rw; r.st = st; r.fl = fl; r.qa = qa; r.qb = qb;
        r.e_v = ev; r.e_d = ed; r.e_rd = erd; r.e_rw = erw; r.e_busy = eb;
        r.e_ha = eha; r.e_da = eda; r.e_hb = ehb; r.e_db = edb;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [63:0] d, input logic [4:0] rd, input logic rw,
                         input logic [2:0] st, input logic [2:0] fl, input logic [4:0] qa,
                         input logic [4:0] qb);
        bus.in_valid = v; bus.in_data = d; bus.in_rd = rd; bus.in_regwrite = rw;
        bus.stall_at = st; bus.flush = fl; bus.q_rs_a = qa; bus.q_rs_b = qb;
    endtask

    task automatic chk_fwd_zero(input string tag);
        chk({tag, " fwd_hit_a"}, 64'(bus.fwd_hit_a), 64'd0);
        chk({tag, " fwd_data_a"}, bus.fwd_data_a, 64'd0);
        chk({tag, " fwd_hit_b"}, 64'(bus.fwd_hit_b), 64'd0);
        chk({tag, " fwd_data_b"}, bus.fwd_data_b, 64'd0);
    endtask

    initial begin
        // latency
        tbl.push_back(mk(1, 'hA5, 3, 1, 0, 0, 0, 0,  0, 0, 0, 0, 1,  0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 3, 0,     0, 0, 0, 0, 1,  1, 'hA5, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,     1, 'hA5, 3, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,     0, 0, 0, 0, 0,  0, 0, 0, 0));
        // stall and bubble: stream 1,2,3,4
        tbl.push_back(mk(1, 1, 1, 1, 0, 0, 0, 0,     0, 0, 0, 0, 1,  0, 0, 0, 0));
        tbl.push_back(mk(1, 2, 2, 1, 0, 0, 0, 0,     0, 0, 0, 0, 1,  0, 0, 0, 0));
        tbl.push_back(mk(1, 3, 3, 1, 0, 0, 2, 3,     1, 1, 1, 1, 1,  1, 2, 1, 3));
        tbl.push_back(mk(1, 4, 4, 1, 3'b010, 0, 4, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4, 4, 1, 0, 0, 0, 0,     1, 2, 2, 1, 1,  0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,     1, 3, 3, 1, 1,  0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,     1, 4, 4, 1, 1,  0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,     0, 0, 0, 0, 0,  0, 0, 0, 0));
        // flush beats hold on stage 1
        tbl.push_back(mk(1, 7, 7, 1, 0, 0, 0, 0,     0, 0, 0, 0, 1,  0, 0, 0, 0));
        tbl.push_back(mk(1, 8, 8, 1, 0, 0, 0, 0,     0, 0, 0, 0, 1,  0, 0, 0, 0));
        tbl.push_back(mk(1, 9, 9, 1, 3'b010, 3'b010, 7, 8, 0, 0, 0, 0, 1, 0, 0, 1, 8));
        tbl.push_back(mk(1, 9, 9, 1, 0, 0, 0, 0,     0, 0, 0, 0, 1,  0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,     1, 8, 8, 1, 1,  0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,     1, 9, 9, 1, 1,  0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,     0, 0, 0, 0, 0,  0, 0, 0, 0));
        // forwarding: youngest wins, XZR never hits, invalid never hits
        tbl.push_back(mk(1, 'h22, 5, 1, 0, 0, 0, 0,  0, 0, 0, 0, 1,  0, 0, 0, 0));
        tbl.push_back(mk(1, 'h33, 6, 1, 0, 0, 0, 0,  0, 0, 0, 0, 1,  0, 0, 0, 0));
        tbl.push_back(mk(1, 'h11, 5, 1, 0, 0, 5, 6,  1, 'h22, 5, 1, 1, 1, 'h11, 1, 'h33));
        tbl.push_back(mk(1, 'h44, 31, 1, 0, 0, 5, 31, 1, 'h33, 6, 1, 1, 1, 'h11, 0, 0));
        tbl.push_back(mk(0, 'h55, 4, 1, 0, 0, 4, 31, 1, 'h11, 5, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 4, 5,     1, 'h44, 31, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 4, 0,     0, 0, 0, 0, 0,  0, 0, 0, 0));
        // flush and stall together on the output stage
        tbl.push_back(mk(1, 'hA1, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 1,  0, 0, 0, 0));
        tbl.push_back(mk(1, 'hA2, 2, 1, 0, 0, 0, 0,  0, 0, 0, 0, 1,  0, 0, 0, 0));
        tbl.push_back(mk(1, 'hA3, 3, 1, 0, 0, 0, 0,  1, 'hA1, 1, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 'hA4, 4, 1, 3'b100, 3'b100, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 'hA4, 4, 1, 0, 0, 0, 0,  1, 'hA2, 2, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,     1, 'hA3, 3, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,     1, 'hA4, 4, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,     0, 0, 0, 0, 0,  0, 0, 0, 0));

        // reset for two edges, outputs must be zero
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        chk("reset out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset out_data", bus.out_data, 64'd0);
        chk("reset out_rd", 64'(bus.out_rd), 64'd0);
        chk("reset out_regwrite", 64'(bus.out_regwrite), 64'd0);
        chk("reset busy", 64'(bus.busy), 64'd0);
        chk_fwd_zero("reset");
        $display("reset: out_valid=%0b busy=%0b", bus.out_valid, bus.busy);
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            vec_t r;
            logic        x_ha, x_hb;
            logic [63:0] x_da, x_db;
            r = tbl[i];
            drive(r.v, r.d, r.rd, r.rw, r.st, r.fl, r.qa, r.qb);
            tick();
`ifdef PIPE_STAGE_FWD_EN
            x_ha = r.e_ha; x_da = r.e_da; x_hb = r.e_hb; x_db = r.e_db;
`else
            x_ha = 1'b0; x_da = 64'd0; x_hb = 1'b0; x_db = 64'd0;
`endif
            chk($sformatf("row%0d out_valid", i), 64'(bus.out_valid), 64'(r.e_v));
            chk($sformatf("row%0d out_regwrite", i), 64'(bus.out_regwrite), 64'(r.e_rw));
            chk($sformatf("row%0d busy", i), 64'(bus.busy), 64'(r.e_busy));
            if (r.e_v) begin
                chk($sformatf("row%0d out_data", i), bus.out_data, r.e_d);
                chk($sformatf("row%0d out_rd", i), 64'(bus.out_rd), 64'(r.e_rd));
            end
            chk($sformatf("row%0d fwd_hit_a", i), 64'(bus.fwd_hit_a), 64'(x_ha));
            chk($sformatf("row%0d fwd_data_a", i), bus.fwd_data_a, x_da);
            chk($sformatf("row%0d fwd_hit_b", i), 64'(bus.fwd_hit_b), 64'(x_hb));
            chk($sformatf("row%0d fwd_data_b", i), bus.fwd_data_b, x_db);
            $display("row%0d: in v=%0b d=%0h rd=%0d st=%b fl=%b -> out v=%0b d=%0h rd=%0d rw=%0b busy=%0b ha=%0b hb=%0b",
                     i, r.v, r.d, r.rd, r.st, r.fl, bus.out_valid, bus.out_data, bus.out_rd,
                     bus.out_regwrite, bus.busy, bus.fwd_hit_a, bus.fwd_hit_b);
        end

        // mid-stream reset discards three in-flight entries
        drive(1, 'hC1, 10, 1, 0, 0, 0, 0); tick();
        drive(1, 'hC2, 11, 1, 0, 0, 0, 0); tick();
        drive(1, 'hC3, 12, 1, 0, 0, 12, 0); tick();
        chk("mid pre out_valid", 64'(bus.out_valid), 64'd1);
        chk("mid pre out_data", bus.out_data, 64'hC1);
        $display("mid-reset fill: out v=%0b d=%0h busy=%0b", bus.out_valid, bus.out_data, bus.busy);
        reset = 1'b1;
        drive(1, 'hC4, 13, 1, 3'b111, 0, 12, 11);
        tick();
        chk("mid reset busy", 64'(bus.busy), 64'd0);
        chk("mid reset out_valid", 64'(bus.out_valid), 64'd0);
        chk("mid reset out_regwrite", 64'(bus.out_regwrite), 64'd0);
        chk_fwd_zero("mid reset");
        $display("mid-reset edge: out v=%0b busy=%0b", bus.out_valid, bus.busy);
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("post reset busy", 64'(bus.busy), 64'd0);
        chk("post reset out_valid", 64'(bus.out_valid), 64'd0);
        $display("post-reset: out v=%0b busy=%0b", bus.out_valid, bus.busy);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
